subtree_rr_dispatch: RTL
========================

# subtree_rr_dispatch

Round-robin token dispatcher that sits directly above a five-child subtree and feeds one valid/ready stream into one of the child instances per accepted token. It holds a one-entry output register per child, skips children whose slot is occupied, and provides enable/drain control plus status counters for the subtree-level testbench.

## Interface

Parameters:

- NUM_CHILD, 5, number of downstream child streams (2..16).
- DATA_W, 16, token width in bits.
- CNT_W, 16, width of the dispatch counter.

Ports:

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  dispatch enable; low requests a drain.
- in_valid  in  1  upstream token valid.
- in_ready  out  1  upstream token accepted when in_valid && in_ready.
- in_data  in  DATA_W  upstream token.
- out_valid  out  NUM_CHILD  per-child slot valid.
- out_ready  in  NUM_CHILD  per-child consume strobe.
- out_data  out  NUM_CHILD*DATA_W  per-child slot data; child i occupies bits [i*DATA_W +: DATA_W].
- state_o  out  2  current FSM state encoding.
- disp_cnt  out  CNT_W  total tokens accepted since reset; wraps modulo 2^CNT_W.
- busy  out  1  high when any out_valid bit is set.

## Operation

- **Slot free:** slot i is free in a cycle when !out_valid[i] || out_ready[i]. A slot being consumed this cycle counts as free.
- **Pick:** starting at pointer ptr and wrapping modulo NUM_CHILD, sel is the first free slot. any_free is high if at least one slot is free.
- **FSM states:** IDLE=0, RUN=1, DRAIN=2. Encoding 3 is unused and must recover to IDLE on the next cycle.
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> RUN when en=1. This has priority over going to IDLE.
  - DRAIN -> IDLE when en=0 and busy=0 after this cycle's consumes.
- **in_ready:** equals (state==RUN) && any_free. It is combinational from out_ready and state; there is no combinational path from in_valid.
- **Accept** (in_valid && in_ready):
  - slot[sel] loads in_data and out_valid[sel] is set.
  - ptr is set to (sel+1) mod NUM_CHILD.
  - disp_cnt increments by 1.
- **Consume:** for each i with out_valid[i] && out_ready[i] and no load into slot i this cycle, clear out_valid[i].
  - A load and a consume on the same slot in the same cycle leave out_valid[i]=1 with the new data.
- **Slot hold:** while out_valid[i]=1 and out_ready[i]=0, out_data slice i is held stable.
- **Pointer hold:** with no accept, ptr holds.
- **Empty:** all slots free and no input means no change.
- **Full:** no slot free forces in_ready=0, and ptr holds.
- **Reset values:**
  - out_valid=0, out_data=0.
  - ptr=0, state=IDLE, disp_cnt=0.
  - busy=0, in_ready=0.
- **Reset mid-operation:** any pending slots are discarded with no handshake.

## Timing

- Accept in cycle N makes out_valid[sel]=1 visible in cycle N+1, so latency is 1 cycle.
- Sustained throughput is 1 token/cycle whenever at least one slot is free each cycle.
- en falling edge in cycle N: in_ready=0 from cycle N+1. The state register shows DRAIN in N+1. The FSM reaches IDLE the cycle after the last slot is consumed.
- disp_cnt and busy are registered-state outputs; they update the cycle after the triggering event.

## Structure

- Package subtree_pkg holds:
  - typedef enum logic [1:0] dispatch_state_t with IDLE/RUN/DRAIN;
  - localparam default NUM_CHILD=5;
  - a function for wrap-increment modulo NUM_CHILD.
- Sub-module rr_pick:
  - inputs: free mask [NUM_CHILD], ptr;
  - outputs: sel index, any_free;
  - purely combinational rotate-and-priority-encode, and the only combinational logic worth isolating.
- Top level contains the FSM, slot registers, pointer and counter.

## Test plan

- **Reset and idle:** hold rst 3 cycles with en=1 and in_valid=1 -> all outputs at reset values. After release, state=RUN in cycle 1 and the first token goes to child 0.
- **Round-robin:** all out_ready=1, send 10 tokens 0x0001..0x000A back-to-back -> children receive 0,1,2,3,4,0,1,2,3,4 in order, and disp_cnt=10.
- **Skip busy:** out_ready[1]=0 with slot 1 occupied, ptr=1, send 0x00AA -> it lands in child 2 and ptr=3. out_data slice 1 stays unchanged.
- **Full:** all out_ready=0 after 5 accepts -> in_ready=0. Raise out_ready[3] for 1 cycle with in_valid=1 -> slot 3 reloads in the same cycle and out_valid[3] stays 1.
- **Drain:** drop en with 3 occupied slots, release out_ready one per cycle -> in_ready=0 throughout, and state reaches IDLE the cycle after the third consume. Raise en during DRAIN -> state returns to RUN.
- **Counter wrap and mid-op reset:** preload CNT_W=4 build, send 17 tokens -> disp_cnt=1. Assert rst with 2 slots valid -> out_valid=0 next cycle.

Source files
------------

// File: rtl/subtree_pkg.sv
// Shared types and helpers for the subtree round-robin dispatcher.
// Contents: dispatch FSM state type, default child count, and a
// wrap-increment helper used to advance the round-robin pointer.
package subtree_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dispatch_state_t;

  localparam int NUM_CHILD_DEFAULT = 5;

  // Increment v, wrapping back to 0 once it reaches n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/subtree_rr_dispatch_rr_pick.sv
// Round-robin pick: first free slot at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; any_free low tells the caller nothing can be taken.
//
// Ports:
//   free     - per-slot free mask
//   ptr      - starting index for the search
//   sel      - index of the chosen slot (0 when none free)
//   any_free - at least one slot is free
module rr_pick #(
  parameter int NUM_CHILD = 5,
  parameter int PTR_W     = 3
) (
  input  logic [NUM_CHILD-1:0] free,
  input  logic [PTR_W-1:0]     ptr,
  output logic [PTR_W-1:0]     sel,
  output logic                 any_free
);

  int idx;

  // Walk from the farthest offset back to ptr so the nearest free slot
  // is the last one written and therefore wins.
  always_comb begin
    sel      = '0;
    any_free = 1'b0;
    idx      = 0;
    for (int k = NUM_CHILD - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CHILD) idx = idx - NUM_CHILD;
      if (free[idx]) begin
        sel      = PTR_W'(idx);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/subtree_rr_dispatch.sv
// Round-robin dispatcher: one upstream stream fanned into NUM_CHILD one-entry slots.
// Latency: 1 cycle from accept to out_valid of the chosen slot; 1 token/cycle sustained.
// Backpressure: in_ready drops when no slot is free (a slot being consumed counts as free) or when not in RUN.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   en                   - dispatch enable; low drains the slots then idles
//   in_valid/in_ready/in_data - upstream token handshake
//   out_valid/out_ready/out_data - per-child slot, child i at [i*DATA_W +: DATA_W]
//   state_o              - FSM state encoding
//   disp_cnt             - tokens accepted since reset, wrapping
//   busy                 - any slot occupied
module subtree_rr_dispatch
  import subtree_pkg::*;
#(
  parameter int NUM_CHILD = NUM_CHILD_DEFAULT,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic [NUM_CHILD-1:0]        out_valid,
  input  logic [NUM_CHILD-1:0]        out_ready,
  output logic [NUM_CHILD*DATA_W-1:0] out_data,
  output logic [1:0]                  state_o,
  output logic [CNT_W-1:0]            disp_cnt,
  output logic                        busy
);

  localparam int PTR_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

  dispatch_state_t                        state_q, state_d;
  logic [PTR_W-1:0]                       ptr_q;
  logic [PTR_W-1:0]                       sel;
  logic                                   any_free;
  logic                                   accept;
  logic [NUM_CHILD-1:0]                   vld_q, vld_d, free, load;
  logic [NUM_CHILD-1:0][DATA_W-1:0]       slot_q;
  logic [CNT_W-1:0]                       cnt_q;

  // A slot draining this cycle can be refilled in the same cycle.
  assign free = ~vld_q | out_ready;

  rr_pick #(
    .NUM_CHILD (NUM_CHILD),
    .PTR_W     (PTR_W)
  ) u_pick (
    .free     (free),
    .ptr      (ptr_q),
    .sel      (sel),
    .any_free (any_free)
  );

  assign in_ready = (state_q == RUN) && any_free;
  assign accept   = in_valid && in_ready;

  // Load wins over consume on the same slot.
  always_comb begin
    load = '0;
    if (accept) load[sel] = 1'b1;
    vld_d = (vld_q & ~out_ready) | load;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)                 state_d = RUN;
        else if (vld_d == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      if (accept) begin
        ptr_q <= PTR_W'(wrap_inc(32'(sel), NUM_CHILD));
        cnt_q <= cnt_q + CNT_W'(1);
      end
      for (int i = 0; i < NUM_CHILD; i++) begin
        if (load[i]) slot_q[i] <= in_data;
      end
    end
  end

  assign out_valid = vld_q;
  assign out_data  = slot_q;
  assign state_o   = state_q;
  assign disp_cnt  = cnt_q;
  assign busy      = |vld_q;

endmodule
